// File: rtl/ofmap_pkg.sv
// Shared definitions for the ofmap store path: default geometry, FSM encoding
// and the column-slice position helper.
package ofmap_pkg;

    localparam int PE_SIZE_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Column 0 lives in the most significant slice of a packed row.
    function automatic int col_lsb(input int col, input int pe_size, input int data_width);
        return data_width * (pe_size - 1 - col);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying {valid, data} for one ofmap column.
// A depth of zero collapses to a plain wire.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_s;
            assign unused_s = clk ^ rst;
            assign dout     = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe_r [DEPTH];

            // Shift every cycle; data is captured regardless of its valid bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pipe_r[i] <= '0;
                    end
                end else begin
                    pipe_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign dout = pipe_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ofmap_writer.sv
// De-skews the diagonally drained ofmap columns into aligned rows and writes one
// packed row per cycle to the GLB at sequential addresses, one job per start.
module ofmap_writer
    import ofmap_pkg::*;
#(
    parameter int PE_SIZE    = PE_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [ADDR_WIDTH-1:0]         row_num_i,
    input  logic [PE_SIZE-1:0]            ofmap_valid_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_i,
    output logic                          glb_wren_o,
    output logic [ADDR_WIDTH-1:0]         glb_addr_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    logic [PE_SIZE-1:0]            al_valid_s;
    logic [DATA_WIDTH*PE_SIZE-1:0] al_row_s;

    // Column k waits PE_SIZE-1-k cycles so every column lines up with the last one.
    for (genvar k = 0; k < PE_SIZE; k++) begin : g_col
        localparam int LSB = col_lsb(k, PE_SIZE, DATA_WIDTH);
        logic [DATA_WIDTH:0] dout_s;

        skew_delay_line #(
            .DEPTH (PE_SIZE - 1 - k),
            .WIDTH (DATA_WIDTH + 1)
        ) u_dly (
            .clk  (clk),
            .rst  (rst),
            .din  ({ofmap_valid_i[k], ofmap_row_i[LSB +: DATA_WIDTH]}),
            .dout (dout_s)
        );

        assign al_valid_s[k]                 = dout_s[DATA_WIDTH];
        assign al_row_s[LSB +: DATA_WIDTH]   = dout_s[DATA_WIDTH-1:0];
    end

    state_t                        state_r;
    state_t                        state_n;
    logic [ADDR_WIDTH-1:0]         addr_r;
    logic [ADDR_WIDTH-1:0]         rows_r;
    logic [ADDR_WIDTH-1:0]         cnt_r;
    logic [ADDR_WIDTH-1:0]         cnt_inc_s;
    logic                          wren_r;
    logic [ADDR_WIDTH-1:0]         glb_addr_r;
    logic [DATA_WIDTH*PE_SIZE-1:0] wdata_r;
    logic                          busy_r;
    logic                          done_r;
    logic                          err_r;

    logic al_valid_s0;
    logic skew_err_s;
    logic wr_s;
    logic load_s;
    logic last_s;
    logic err_set_s;

    assign al_valid_s0 = al_valid_s[0];
    assign skew_err_s  = (|al_valid_s) && !(&al_valid_s);
    assign cnt_inc_s   = cnt_r + ADDR_WIDTH'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_n = (row_num_i == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Per-state control strobes; rows arriving outside RUN are flagged and dropped.
    always_comb begin
        wr_s   = 1'b0;
        load_s = 1'b0;
        case (state_r)
            ST_IDLE: load_s = start_i;
            ST_RUN:  wr_s   = al_valid_s0;
            ST_DONE: wr_s   = 1'b0;
            default: wr_s   = 1'b0;
        endcase
        last_s    = wr_s && (cnt_inc_s == rows_r);
        err_set_s = skew_err_s || (al_valid_s0 && (state_r != ST_RUN));
    end

    // Job bookkeeping and registered GLB/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r     <= '0;
            rows_r     <= '0;
            cnt_r      <= '0;
            wren_r     <= 1'b0;
            glb_addr_r <= '0;
            wdata_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            wren_r <= wr_s;
            if (load_s) begin
                addr_r <= base_addr_i;
                rows_r <= row_num_i;
                cnt_r  <= '0;
            end else if (wr_s) begin
                glb_addr_r <= addr_r;
                wdata_r    <= al_row_s;
                addr_r     <= addr_r + ADDR_WIDTH'(1);
                cnt_r      <= cnt_inc_s;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
            busy_r <= (state_n != ST_IDLE);
            done_r <= (state_r == ST_DONE);
        end
    end

    assign glb_wren_o  = wren_r;
    assign glb_addr_o  = glb_addr_r;
    assign glb_wdata_o = wdata_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign err_o       = err_r;

endmodule
